// File: rtl/merge_pkg.sv
// merge_pkg: bus field widths and state encoding shared by the merge concentrator
package merge_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int REQ_W = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RESP_W = DATA_W + 1;
  typedef enum logic {MERGE_IDLE = 1'b0, MERGE_BUSY = 1'b1} merge_state_e;
endpackage

// File: rtl/rr_arb.sv
// rr_arb: rotate-priority encoder; req[N-1:0] and last in, grant_idx (first req after last, modulo N) and any out
module rr_arb #(
  parameter int N = 2,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);
  logic [SEL_W-1:0] idx;
  always_comb begin
    grant_idx = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SEL_W'((int'(last) + k) % N);
      if (req[idx]) begin
        grant_idx = idx;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/merge.sv
// merge: N-master to 1-slave round-robin concentrator; clk/rst_n, m_req/m_resp master slots, s_req/s_resp shared slave
module merge
  import merge_pkg::*;
#(
  parameter int N_MASTERS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_MASTERS*REQ_W-1:0]  m_req,
  output logic [N_MASTERS*RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]            s_req,
  input  logic [RESP_W-1:0]           s_resp
);
  localparam int SEL_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  merge_state_e state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, last_q, last_d, win;
  logic [REQ_W-1:0] req_a [N_MASTERS];
  logic [N_MASTERS-1:0] valids;
  logic any, busy;
  assign busy = state_q == MERGE_BUSY;
  for (genvar g = 0; g < N_MASTERS; g++) begin : g_slot
    assign req_a[g] = m_req[g*REQ_W +: REQ_W];
    assign valids[g] = req_a[g][REQ_W-1];
    assign m_resp[g*RESP_W +: RESP_W] = (busy && sel_q == SEL_W'(g)) ? s_resp : '0;
  end
  assign s_req = busy ? req_a[sel_q] : '0;
  rr_arb #(.N(N_MASTERS), .SEL_W(SEL_W)) u_arb (
    .req(valids),
    .last(last_q),
    .grant_idx(win),
    .any(any)
  );
  // an owner dropping valid without a ready releases the slave but does not count as served
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    if (!busy) begin
      state_d = any ? MERGE_BUSY : MERGE_IDLE;
      sel_d = any ? win : sel_q;
    end else if (s_resp[0] || !valids[sel_q]) begin
      state_d = MERGE_IDLE;
      last_d = s_resp[0] ? sel_q : last_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= MERGE_IDLE;
      sel_q <= '0;
      last_q <= SEL_W'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
    end
endmodule

// File: doc/merge.md
Name: merge

Overview:
- N-master to 1-slave concentrator for the native valid/ready bus; the counterpart of the address-decoding splitter.
- Round-robin arbitration among masters.
- Grant locked for one transaction (valid until ready).
- Sits in front of a shared slave, e.g. main memory fed by the CPU instruction and data ports.

Parameters:
- N_MASTERS, 2, number of master ports; ≥2. SEL_W = max(1, $clog2(N_MASTERS)) is derived.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- m_req  input  N_MASTERS*`REQ_W  master requests, slot i = `req(i); fields {valid, addr, wdata, wstrb}, valid at MSB
- m_resp  output  N_MASTERS*`RESP_W  master responses, slot i = `resp(i); fields {rdata, ready}
- s_req  output  `REQ_W  request to shared slave
- s_resp  input  `RESP_W  response from shared slave

Behaviour:
- States:
  - IDLE: no owner.
  - BUSY: owner sel_q holds the slave.
- Reset (rst_n=0, async):
  - state=IDLE, sel_q=0, last_q=N_MASTERS-1, so master 0 has first priority.
  - s_req=0; m_resp=0.
- IDLE:
  - s_req=0 and every m_resp ready=0, rdata=0.
  - If any master valid=1: winner = first valid index scanning last_q+1, last_q+2, … modulo N_MASTERS.
  - Next edge: sel_q<=winner, state<=BUSY.
  - No valid: stay IDLE.
- BUSY:
  - s_req = m_req slot sel_q (combinational pass-through of all fields).
  - m_resp slot sel_q = s_resp.
  - All other m_resp slots = 0; their valids are ignored and they keep waiting.
- Completion:
  - In BUSY, when s_resp ready=1, next edge: state<=IDLE, last_q<=sel_q.
  - The owner sees ready in the same cycle the slave asserts it.
- Abort: in BUSY, if the owner valid=0 and slave ready=0, next edge state<=IDLE and last_q is unchanged. Owner dropping valid is a protocol violation; this prevents deadlock.
- Latency:
  - One cycle from master valid (IDLE) to slave valid.
  - Response adds zero cycles.
  - Minimum transaction = 2 cycles, with a 1-cycle IDLE gap between back-to-back grants.
- Fairness:
  - A master just served has lowest priority at the next arbitration.
  - With all N valid continuously, each is served once per N grants.
- Simultaneous events:
  - A master's valid rising in the same cycle as the owner's ready is considered at the next IDLE cycle.
  - The arbitration decision uses only IDLE-cycle valids.
- Ready in the first BUSY cycle (combinational slave) is legal; the transaction completes in that cycle.
- Reset mid-transaction:
  - Immediately forces IDLE outputs (s_req valid=0, m_resp ready=0).
  - In-flight transaction is dropped; the master re-issues.
- N_MASTERS not a power of 2: indices ≥N_MASTERS are never granted; modulo wrap uses N_MASTERS, not 2^SEL_W.
- Width: pure routing; no field is modified or truncated.

Decomposition:
- interconnect.vh already supplies REQ_W, RESP_W and the slot macros req(i), resp(i), valid(i), ready(i).
- Add to that header: state encodings MERGE_IDLE=1'b0, MERGE_BUSY=1'b1.
- One sub-module: rr_arb.
  - Parameter N; inputs req[N-1:0], last[SEL_W-1:0]; outputs grant_idx[SEL_W-1:0], any.
  - Purely combinational rotate-priority encoder.
  - Reusable by future multi-master blocks.

Test Plan:
- Reset release, no valids for 10 cycles -> state IDLE, s_req=0, all m_resp=0.
- Single master: master 1 issues addr=0x100, wdata=0xDEADBEEF, wstrb=0xF; slave ready 2 cycles after s_req valid -> s_req matches at cycle+1; m_resp[1] ready=1 exactly in the slave-ready cycle; m_resp[0]=0 throughout.
- Contention, N=2, both valid at cycle 0 after reset -> master 0 granted first, then master 1 after one IDLE gap. Order continues 0,1,0,1 while both stay valid.
- Read routing: master 0 read, slave returns rdata=0x12345678 with ready -> m_resp[0] rdata=0x12345678; m_resp[1] rdata=0.
- N_MASTERS=3, masters 0 and 2 valid, last_q=0 -> master 2 granted; next grant is master 0.
- Async reset asserted in BUSY between clock edges -> s_req valid and m_resp ready drop without waiting for clk. After release, master 0 has first priority.
